// File: rtl/determ_mult_seq_pkg.sv
// rtl/determ_mult_seq_pkg.sv - shared state encodings and width helper for determ_mult_seq
package determ_mult_seq_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // The ones-count spans 0..L^2 inclusive, which needs one bit beyond 2N.
    function automatic int count_width(input int n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/determ_mult_seq_determ_mult.sv
// rtl/determ_mult_seq_determ_mult.sv - bipolar stochastic multiplier, one XNOR gate
module determ_mult (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);

    assign o_y = ~(i_a ^ i_b);

endmodule

// File: rtl/determ_mult_seq.sv
// rtl/determ_mult_seq.sv - clock-division sequencer producing an exact bipolar product count
module determ_mult_seq
    import determ_mult_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic                              start,
    input  logic                              stop,
    input  logic [N:0]                        ka,
    input  logic [N:0]                        kb,
    output logic                              busy,
    output logic                              done,
    output logic                              a_bit,
    output logic                              b_bit,
    output logic                              y_bit,
    output logic [count_width(N)-1:0]         count
);

    localparam int         CW    = count_width(N);
    localparam logic [N:0] L_LVL = {1'b1, {N{1'b0}}};

    logic [1:0]    r_state;
    logic [N-1:0]  r_i;
    logic [N-1:0]  r_j;
    logic [N:0]    r_ka;
    logic [N:0]    r_kb;
    logic [CW-1:0] r_count;

    logic          w_run;
    logic          w_last;
    logic          w_a;
    logic          w_b;
    logic          w_y;
    logic [N:0]    w_ka_clamped;
    logic [N:0]    w_kb_clamped;

    assign w_ka_clamped = (ka > L_LVL) ? L_LVL : ka;
    assign w_kb_clamped = (kb > L_LVL) ? L_LVL : kb;

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_i == {N{1'b1}}) && (r_j == {N{1'b1}});

    // Streams are gated by RUN so idle outputs settle to a=0, b=0, y=1.
    assign w_a = w_run && ({1'b0, r_i} < r_ka);
    assign w_b = w_run && ({1'b0, r_j} < r_kb);

    determ_mult u_mult (
        .i_a (w_a),
        .i_b (w_b),
        .o_y (w_y)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_ka    <= '0;
            r_kb    <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_state <= S_RUN;
                        r_ka    <= w_ka_clamped;
                        r_kb    <= w_kb_clamped;
                        r_count <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                    end
                end
                S_RUN: begin
                    r_count <= r_count + {{(CW-1){1'b0}}, w_y};
                    r_i     <= r_i + 1'b1;
                    if (r_i == {N{1'b1}}) begin
                        r_j <= r_j + 1'b1;
                    end
                    // Abort outranks completion, even on the final cycle.
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = w_run;
    assign done  = (r_state == S_DONE);
    assign a_bit = w_a;
    assign b_bit = w_b;
    assign y_bit = w_y;
    assign count = r_count;

endmodule

// File: tb/tb_determ_mult_seq.sv
// tb/tb_determ_mult_seq.sv - directed self-checking bench for determ_mult_seq with N=4
module tb_determ_mult_seq;

    logic       CLK;
    logic       nRST;
    logic       start;
    logic       stop;
    logic [4:0] ka;
    logic [4:0] kb;
    logic       busy;
    logic       done;
    logic       a_bit;
    logic       b_bit;
    logic       y_bit;
    logic [8:0] count;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_done = 0;

    determ_mult_seq #(.N(4)) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .start (start),
        .stop  (stop),
        .ka    (ka),
        .kb    (kb),
        .busy  (busy),
        .done  (done),
        .a_bit (a_bit),
        .b_bit (b_bit),
        .y_bit (y_bit),
        .count (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (done === 1'b1) n_done++;
    end

    initial begin
        #5ms;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input int exp_cnt);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_a"}, 32'(a_bit), 0);
        chk({tag, "_b"}, 32'(b_bit), 0);
        chk({tag, "_y"}, 32'(y_bit), 1);
        chk({tag, "_count"}, 32'(count), exp_cnt);
    endtask

    // mode 0: plain run, 1: start re-pulsed at cycle evk, 2: stop at evk, 3: reset at evk
    task automatic do_run(input int a, input int b, input int mode, input int evk);
        int ca, cb, exp_cnt, errs, part, ea, eb;
        ca = (a > 16) ? 16 : a;
        cb = (b > 16) ? 16 : b;
        exp_cnt = ca * cb + (16 - ca) * (16 - cb);
        @(posedge CLK); #1;
        ka = 5'(a);
        kb = 5'(b);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        errs = 0;
        part = 0;
        for (int k = 0; k < 256; k++) begin
            ea = ((k % 16) < ca) ? 1 : 0;
            eb = ((k / 16) < cb) ? 1 : 0;
            if (busy !== 1'b1 || done !== 1'b0 || a_bit !== ea[0] || b_bit !== eb[0] ||
                y_bit !== (ea[0] ~^ eb[0]))
                errs++;
            part += (ea == eb) ? 1 : 0;
            if (mode == 1 && k == evk) begin
                start = 1'b1;
                ka = 5'd3;
                kb = 5'd9;
            end
            if (mode == 1 && k == evk + 1) start = 1'b0;
            if (mode == 2 && k == evk) stop = 1'b1;
            if (mode == 3 && k == evk) nRST = 1'b0;
            @(posedge CLK); #1;
            if (mode >= 2 && k == evk) begin
                stop = 1'b0;
                nRST = 1'b1;
                chk($sformatf("abort%0d_stream", mode), 32'(errs), 0);
                chk_idle_outputs($sformatf("abort%0d", mode), (mode == 2) ? part : 0);
                repeat (3) begin
                    @(posedge CLK); #1;
                end
                chk($sformatf("abort%0d_hold_count", mode), 32'(count), (mode == 2) ? part : 0);
                chk($sformatf("abort%0d_still_idle", mode), 32'(busy), 0);
                return;
            end
        end
        n_acc++;
        chk($sformatf("run_%0d_%0d_stream", a, b), 32'(errs), 0);
        chk($sformatf("run_%0d_%0d_done", a, b), 32'(done), 1);
        chk($sformatf("run_%0d_%0d_busy_off", a, b), 32'(busy), 0);
        chk($sformatf("run_%0d_%0d_count", a, b), 32'(count), exp_cnt);
        @(posedge CLK); #1;
        chk($sformatf("run_%0d_%0d_done_pulse", a, b), 32'(done), 0);
        chk($sformatf("run_%0d_%0d_count_hold", a, b), 32'(count), exp_cnt);
    endtask

    initial begin
        nRST  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        ka    = 5'd0;
        kb    = 5'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk_idle_outputs("reset", 0);
        nRST = 1'b1;

        do_run(16, 16, 0, 0);
        chk("hand_16_16", 32'(count), 256);
        do_run(12, 4, 0, 0);
        chk("hand_12_4", 32'(count), 96);
        do_run(8, 0, 0, 0);
        chk("hand_8_0", 32'(count), 128);
        do_run(8, 5, 0, 0);
        chk("hand_8_5", 32'(count), 128);
        do_run(8, 16, 0, 0);
        chk("hand_8_16", 32'(count), 128);
        do_run(0, 16, 0, 0);
        chk("hand_0_16", 32'(count), 0);
        do_run(20, 0, 0, 0);
        chk("hand_clamp_20_0", 32'(count), 0);

        do_run(12, 4, 3, 100);
        do_run(12, 4, 2, 50);
        do_run(5, 11, 2, 255);
        do_run(12, 4, 1, 30);
        chk("glitch_start_result", 32'(count), 96);

        @(posedge CLK); #1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle_busy", 32'(busy), 0);

        for (int a = 0; a <= 16; a++) begin
            for (int b = 0; b <= 16; b++) begin
                repeat ($urandom_range(0, 3)) @(posedge CLK);
                do_run(a, b, 0, 0);
            end
        end

        repeat (2) @(posedge CLK);
        #1;
        chk("done_pulse_total", 32'(n_done), 32'(n_acc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
